// File: rtl/vend_credit_if.sv
// Coin/vend/change signal bundle between the coin front-end (master) and the
// credit controller (slave).
interface vend_credit_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          coins;
  logic                change_ready;
  logic                coffee;
  logic                change_valid;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                busy;

  modport master (
    output coins,
    output change_ready,
    input  coffee,
    input  change_valid,
    input  credit,
    input  coin_reject,
    input  busy
  );

  modport slave (
    input  coins,
    input  change_ready,
    output coffee,
    output change_valid,
    output credit,
    output coin_reject,
    output busy
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// Coin-credit vending controller: accumulates 5-cent credit, vends for a fixed
// number of cycles, carries remainder over, and refunds change one coin at a time.
module vend_credit_fsm #(
  parameter int PRICE       = 3,
  parameter int MAX_CREDIT  = 7,
  parameter int CREDIT_W    = 4,
  parameter int VEND_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  vend_credit_if.slave bus
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;
  localparam logic [SUM_W-1:0] PRICE_X    = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0] MAX_X      = SUM_W'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(VEND_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                reject_reg, reject_next;

  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    acc;
  logic                is_coin;
  logic                fits;
  logic                refund;

  always_comb begin
    case (bus.coins)
      2'b01:   coin_val = SUM_W'(2);
      2'b10:   coin_val = SUM_W'(1);
      default: coin_val = '0;
    endcase
  end

  // Sum is one bit wider than credit so the overflow test cannot wrap.
  assign sum     = {1'b0, credit_reg} + coin_val;
  assign fits    = (sum <= MAX_X);
  assign is_coin = (bus.coins == 2'b01) || (bus.coins == 2'b10);
  assign refund  = (bus.coins == 2'b11);
  assign acc     = fits ? sum : {1'b0, credit_reg};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= COLLECT;
      credit_reg <= '0;
      cnt_reg    <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      cnt_reg    <= cnt_next;
      reject_reg <= reject_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    cnt_next    = cnt_reg;
    reject_next = 1'b0;
    case (state_reg)
      COLLECT: begin
        reject_next = is_coin && !fits;
        if (acc >= PRICE_X) begin
          state_next  = VEND;
          credit_next = CREDIT_W'(acc - PRICE_X);
          cnt_next    = CNT_LOAD;
        end else if (refund && (credit_reg != '0)) begin
          state_next = CHANGE;
        end else begin
          credit_next = CREDIT_W'(acc);
        end
      end
      VEND: begin
        reject_next = is_coin && !fits;
        credit_next = CREDIT_W'(acc);
        if (cnt_reg == '0) begin
          state_next = COLLECT;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      CHANGE: begin
        // Coins cannot be credited while change is being paid out.
        reject_next = is_coin;
        if (credit_reg == '0) begin
          state_next = COLLECT;
        end else if (bus.change_ready) begin
          credit_next = credit_reg - 1'b1;
          if (credit_reg == CREDIT_W'(1)) begin
            state_next = COLLECT;
          end
        end
      end
      default: begin
        state_next  = COLLECT;
        credit_next = '0;
        cnt_next    = '0;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.coffee       = (state_reg == VEND);
    bus.change_valid = (state_reg == CHANGE);
    bus.busy         = (state_reg != COLLECT);
    bus.credit       = credit_reg;
    bus.coin_reject  = reject_reg;
  end

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Directed bench for vend_credit_fsm: default-parameter instance A and a
// PRICE=5 / MAX_CREDIT=9 / VEND_CYCLES=1 instance B sharing one clock.
module tb_vend_credit_fsm;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total;
  int   bad;

  vend_credit_if #(.CREDIT_W(4)) bus_a ();
  vend_credit_if #(.CREDIT_W(4)) bus_b ();

  vend_credit_fsm #(
    .PRICE(3), .MAX_CREDIT(7), .CREDIT_W(4), .VEND_CYCLES(4)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  vend_credit_fsm #(
    .PRICE(5), .MAX_CREDIT(9), .CREDIT_W(4), .VEND_CYCLES(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {coffee, change_valid, busy, coin_reject, credit[3:0]}
  function automatic logic [7:0] pk(input bit cf, input bit cv, input bit bs,
                                    input bit rj, input int cr);
    logic [3:0] c4;
    c4 = cr[3:0];
    return {cf, cv, bs, rj, c4};
  endfunction

  function automatic logic [7:0] snap_a();
    return {bus_a.coffee, bus_a.change_valid, bus_a.busy, bus_a.coin_reject, bus_a.credit};
  endfunction

  function automatic logic [7:0] snap_b();
    return {bus_b.coffee, bus_b.change_valid, bus_b.busy, bus_b.coin_reject, bus_b.credit};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.coins = 2'b00; bus_a.change_ready = 1'b0;
    bus_b.coins = 2'b00; bus_b.change_ready = 1'b0;
    tick(); tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL reset_a got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    total++; if (snap_b() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL reset_b got=%h exp=%h", snap_b(), pk(0,0,0,0,0)); end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL post_reset_a got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    $display("test_reset done");
  endtask

  task automatic test_basic_vend();
    bus_a.coins = 2'b10; tick();
    total++; if (snap_a() !== pk(0,0,0,0,1)) begin bad++; $display("FAIL s1_c1 got=%h exp=%h", snap_a(), pk(0,0,0,0,1)); end
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,2)) begin bad++; $display("FAIL s1_c2 got=%h exp=%h", snap_a(), pk(0,0,0,0,2)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,0)) begin bad++; $display("FAIL s1_v0 got=%h exp=%h", snap_a(), pk(1,0,1,0,0)); end
    bus_a.coins = 2'b00;
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (snap_a() !== pk(1,0,1,0,0)) begin bad++; $display("FAIL s1_v%0d got=%h exp=%h", i, snap_a(), pk(1,0,1,0,0)); end
    end
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s1_end got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    $display("test_basic_vend done");
  endtask

  task automatic test_refund_after_vend();
    bus_a.coins = 2'b01; tick();
    total++; if (snap_a() !== pk(0,0,0,0,2)) begin bad++; $display("FAIL s2_c1 got=%h exp=%h", snap_a(), pk(0,0,0,0,2)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,1)) begin bad++; $display("FAIL s2_v0 got=%h exp=%h", snap_a(), pk(1,0,1,0,1)); end
    bus_a.coins = 2'b00;
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (snap_a() !== pk(1,0,1,0,1)) begin bad++; $display("FAIL s2_v%0d got=%h exp=%h", i, snap_a(), pk(1,0,1,0,1)); end
    end
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,1)) begin bad++; $display("FAIL s2_idle got=%h exp=%h", snap_a(), pk(0,0,0,0,1)); end
    bus_a.coins = 2'b11; bus_a.change_ready = 1'b1; tick();
    total++; if (snap_a() !== pk(0,1,1,0,1)) begin bad++; $display("FAIL s2_change got=%h exp=%h", snap_a(), pk(0,1,1,0,1)); end
    bus_a.coins = 2'b00; tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s2_done got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    bus_a.change_ready = 1'b0;
    $display("test_refund_after_vend done");
  endtask

  task automatic test_overflow_back_to_back();
    bus_a.coins = 2'b01; tick();
    total++; if (snap_a() !== pk(0,0,0,0,2)) begin bad++; $display("FAIL s3_c1 got=%h exp=%h", snap_a(), pk(0,0,0,0,2)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,1)) begin bad++; $display("FAIL s3_v0 got=%h exp=%h", snap_a(), pk(1,0,1,0,1)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,3)) begin bad++; $display("FAIL s3_add3 got=%h exp=%h", snap_a(), pk(1,0,1,0,3)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,5)) begin bad++; $display("FAIL s3_add5 got=%h exp=%h", snap_a(), pk(1,0,1,0,5)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,7)) begin bad++; $display("FAIL s3_add7 got=%h exp=%h", snap_a(), pk(1,0,1,0,7)); end
    bus_a.coins = 2'b10; tick();
    total++; if (snap_a() !== pk(0,0,0,1,7)) begin bad++; $display("FAIL s3_reject got=%h exp=%h", snap_a(), pk(0,0,0,1,7)); end
    bus_a.coins = 2'b00; tick();
    total++; if (snap_a() !== pk(1,0,1,0,4)) begin bad++; $display("FAIL s3_vend2 got=%h exp=%h", snap_a(), pk(1,0,1,0,4)); end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (snap_a() !== pk(1,0,1,0,4)) begin bad++; $display("FAIL s3_v2_%0d got=%h exp=%h", i, snap_a(), pk(1,0,1,0,4)); end
    end
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,4)) begin bad++; $display("FAIL s3_gap got=%h exp=%h", snap_a(), pk(0,0,0,0,4)); end
    tick();
    total++; if (snap_a() !== pk(1,0,1,0,1)) begin bad++; $display("FAIL s3_vend3 got=%h exp=%h", snap_a(), pk(1,0,1,0,1)); end
    tick(); tick(); tick(); tick();
    total++; if (snap_a() !== pk(0,0,0,0,1)) begin bad++; $display("FAIL s3_end got=%h exp=%h", snap_a(), pk(0,0,0,0,1)); end
    $display("test_overflow_back_to_back done");
  endtask

  task automatic test_backpressure();
    bus_a.coins = 2'b10; tick();
    total++; if (snap_a() !== pk(0,0,0,0,2)) begin bad++; $display("FAIL s4_c got=%h exp=%h", snap_a(), pk(0,0,0,0,2)); end
    bus_a.coins = 2'b11; bus_a.change_ready = 1'b0; tick();
    total++; if (snap_a() !== pk(0,1,1,0,2)) begin bad++; $display("FAIL s4_enter got=%h exp=%h", snap_a(), pk(0,1,1,0,2)); end
    bus_a.coins = 2'b10; tick();
    total++; if (snap_a() !== pk(0,1,1,1,2)) begin bad++; $display("FAIL s4_reject got=%h exp=%h", snap_a(), pk(0,1,1,1,2)); end
    bus_a.coins = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (snap_a() !== pk(0,1,1,0,2)) begin bad++; $display("FAIL s4_hold%0d got=%h exp=%h", i, snap_a(), pk(0,1,1,0,2)); end
    end
    bus_a.change_ready = 1'b1; tick();
    total++; if (snap_a() !== pk(0,1,1,0,1)) begin bad++; $display("FAIL s4_pay1 got=%h exp=%h", snap_a(), pk(0,1,1,0,1)); end
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s4_pay2 got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    bus_a.change_ready = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_refund_ignored();
    bus_a.coins = 2'b11; tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s5_zero got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    bus_a.coins = 2'b10; tick(); tick(); tick();
    total++; if (snap_a() !== pk(1,0,1,0,0)) begin bad++; $display("FAIL s5_vend got=%h exp=%h", snap_a(), pk(1,0,1,0,0)); end
    bus_a.coins = 2'b11; tick();
    total++; if (snap_a() !== pk(1,0,1,0,0)) begin bad++; $display("FAIL s5_refund_vend got=%h exp=%h", snap_a(), pk(1,0,1,0,0)); end
    bus_a.coins = 2'b00; tick(); tick(); tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s5_end got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s5_not_queued got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    $display("test_refund_ignored done");
  endtask

  task automatic test_reset_mid();
    bus_a.coins = 2'b01; tick(); tick();
    total++; if (snap_a() !== pk(1,0,1,0,1)) begin bad++; $display("FAIL s6_vend got=%h exp=%h", snap_a(), pk(1,0,1,0,1)); end
    bus_a.coins = 2'b00; rst_a = 1'b1; tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s6_rst_vend got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    rst_a = 1'b0; tick(); tick();
    total++; if (snap_a() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s6_after_vend got=%h exp=%h", snap_a(), pk(0,0,0,0,0)); end
    bus_b.coins = 2'b01; tick();
    bus_b.coins = 2'b10; tick();
    total++; if (snap_b() !== pk(0,0,0,0,3)) begin bad++; $display("FAIL s6_b_credit got=%h exp=%h", snap_b(), pk(0,0,0,0,3)); end
    bus_b.coins = 2'b11; tick();
    total++; if (snap_b() !== pk(0,1,1,0,3)) begin bad++; $display("FAIL s6_b_change got=%h exp=%h", snap_b(), pk(0,1,1,0,3)); end
    bus_b.coins = 2'b00; rst_b = 1'b1; tick();
    total++; if (snap_b() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s6_rst_change got=%h exp=%h", snap_b(), pk(0,0,0,0,0)); end
    rst_b = 1'b0; bus_b.change_ready = 1'b1; tick();
    total++; if (snap_b() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s6_after_change got=%h exp=%h", snap_b(), pk(0,0,0,0,0)); end
    bus_b.change_ready = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_small_price();
    bus_b.coins = 2'b01; tick();
    total++; if (snap_b() !== pk(0,0,0,0,2)) begin bad++; $display("FAIL s7_c1 got=%h exp=%h", snap_b(), pk(0,0,0,0,2)); end
    tick();
    total++; if (snap_b() !== pk(0,0,0,0,4)) begin bad++; $display("FAIL s7_c2 got=%h exp=%h", snap_b(), pk(0,0,0,0,4)); end
    bus_b.coins = 2'b10; tick();
    total++; if (snap_b() !== pk(1,0,1,0,0)) begin bad++; $display("FAIL s7_vend got=%h exp=%h", snap_b(), pk(1,0,1,0,0)); end
    bus_b.coins = 2'b00; tick();
    total++; if (snap_b() !== pk(0,0,0,0,0)) begin bad++; $display("FAIL s7_end got=%h exp=%h", snap_b(), pk(0,0,0,0,0)); end
    $display("test_small_price done");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_vend();
    test_refund_after_vend();
    test_overflow_back_to_back();
    test_backpressure();
    test_refund_ignored();
    test_reset_mid();
    test_small_price();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
